// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and helpers for the countdown timer controller.
// State encodings are fixed because they are exported on the debug state port.
package countdown_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_e;

    // Prescaler register width; at least one bit even when PRESCALE is 1.
    function automatic int unsigned presc_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/down_counter_sync.sv
// Synchronous loadable down-counter; load wins over enable and the value never wraps below 0.
module down_counter_sync #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero_next
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (en && (r_q != '0)) begin
            r_q <= r_q - 1'b1;
        end
    end

    assign q         = r_q;
    assign zero_next = (r_q == WIDTH'(1)) && en;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer sequencer: command FSM, clock-enable prescaler and reload register
// driving a synchronous down-counter.
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int unsigned PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    timer_state_e     r_state;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_reload;

    logic             w_tick;
    logic             w_load;
    logic             w_en;
    logic [WIDTH-1:0] w_d;
    logic             w_zero_next;

    assign w_tick = (r_presc == PRESC_LAST);

    // Counter control; abort clears the count through a load of zero.
    always_comb begin
        w_load = 1'b0;
        w_en   = 1'b0;
        w_d    = '0;
        if (abort) begin
            w_load = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_load = 1'b1;
                        w_d    = load_val;
                    end
                end
                ST_RUN: begin
                    if (!stop) begin
                        w_en = w_tick;
                    end
                end
                ST_DONE: begin
                    if (auto_reload && (r_reload != '0)) begin
                        w_load = 1'b1;
                        w_d    = r_reload;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_reload <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_reload <= load_val;
                        r_presc  <= '0;
                        r_state  <= (load_val != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    // A stop freezes the prescaler and suppresses this cycle's tick.
                    if (stop) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_zero_next) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (auto_reload && (r_reload != '0)) begin
                        r_presc <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    down_counter_sync #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .en       (w_en),
        .d        (w_d),
        .q        (count),
        .zero_next(w_zero_next)
    );

    assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done  = (r_state == ST_DONE);
    assign state = r_state;

endmodule
